// File: rtl/input_event_queue.sv
// -----------------------------------------------------------------------------
// input_event_queue
//
// Synchronises, debounces and polarity-normalises NUM_IN asynchronous inputs.
// Every committed level change is queued with its input index, the new
// logical level and a timestamp. The queue is drained over valid/ready, and a
// registered level interrupt reports a non-empty queue or a dropped event.
//
// Ports
//   clk_clk        in   system clock
//   reset_reset_n  in   asynchronous active-low reset
//   raw_in         in   unsynchronised input pins
//   evt_ready      in   consumer accepts the head entry
//   clear_overflow in   single-cycle pulse, clears the sticky overflow flag
//   evt_valid      out  queue non-empty, evt_* carry the head entry
//   evt_index      out  input number of the head event
//   evt_level      out  new logical level of that input
//   evt_timestamp  out  timestamp captured at debounce commit
//   stable_state   out  current debounced logical levels
//   fifo_count     out  number of queued entries
//   overflow       out  sticky, an event was dropped on a full queue
//   irq            out  fifo_count >= IRQ_THRESHOLD or overflow
// -----------------------------------------------------------------------------
module input_event_queue #(
    parameter int                NUM_IN          = 14,
    parameter logic [NUM_IN-1:0] ACTIVE_LOW_MASK = NUM_IN'(14'h00F),
    parameter int                DEBOUNCE_CYCLES = 50000,
    parameter int                FIFO_DEPTH      = 16,
    parameter int                TS_WIDTH        = 16,
    parameter int                IRQ_THRESHOLD   = 1
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic [NUM_IN-1:0]             raw_in,
    input  logic                          evt_ready,
    input  logic                          clear_overflow,
    output logic                          evt_valid,
    output logic [$clog2(NUM_IN)-1:0]     evt_index,
    output logic                          evt_level,
    output logic [TS_WIDTH-1:0]           evt_timestamp,
    output logic [NUM_IN-1:0]             stable_state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          irq
);

    localparam int IDX_W   = $clog2(NUM_IN);
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_FW  = PTR_W + 1;
    localparam int ENTRY_W = IDX_W + 1 + TS_WIDTH;

    localparam logic [CNT_W-1:0]  DBC_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_FW-1:0] FIFO_FULL = CNT_FW'(FIFO_DEPTH);
    localparam logic [CNT_FW-1:0] IRQ_LEVEL = CNT_FW'(IRQ_THRESHOLD);

    logic [NUM_IN-1:0]   sync1_q, sync2_q;
    logic [NUM_IN-1:0]   s_lvl;
    logic [NUM_IN-1:0]   stable_q, stable_d;
    logic [NUM_IN-1:0]   pending_q, pending_d;
    logic [NUM_IN-1:0]   commit;
    logic [NUM_IN-1:0]   grant;
    logic [CNT_W-1:0]    dbc_q   [NUM_IN];
    logic [CNT_W-1:0]    dbc_d   [NUM_IN];
    logic [TS_WIDTH-1:0] tscap_q [NUM_IN];
    logic [TS_WIDTH-1:0] tscap_d [NUM_IN];
    logic [TS_WIDTH-1:0] ts_q;

    logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_FW-1:0]   count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                irq_q, irq_d;

    logic                push_req;
    logic [IDX_W-1:0]    push_idx;
    logic                push_lvl;
    logic [TS_WIDTH-1:0] push_ts;
    logic                pop, full, do_write, drop;

    // Sync stages reset to the idle raw level so release does not look like
    // a transition on active-low inputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q <= ACTIVE_LOW_MASK;
            sync2_q <= ACTIVE_LOW_MASK;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    assign s_lvl = sync2_q ^ ACTIVE_LOW_MASK;

    // Per-input debounce: the counter tracks how long the synchronised level
    // has disagreed with the stable level; any agreement restarts it.
    always_comb begin
        stable_d = stable_q;
        commit   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            dbc_d[i]   = dbc_q[i];
            tscap_d[i] = tscap_q[i];
            if (s_lvl[i] == stable_q[i]) begin
                dbc_d[i] = '0;
            end else if (dbc_q[i] == DBC_LAST) begin
                stable_d[i] = s_lvl[i];
                dbc_d[i]    = '0;
                commit[i]   = 1'b1;
                tscap_d[i]  = ts_q;
            end else begin
                dbc_d[i] = dbc_q[i] + CNT_W'(1);
            end
        end
    end

    // Fixed priority, lowest index wins. The payload comes from the
    // registered stable level and captured timestamp of the granted input.
    always_comb begin
        push_req = 1'b0;
        push_idx = '0;
        push_lvl = 1'b0;
        push_ts  = '0;
        grant    = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (pending_q[i] && !push_req) begin
                push_req = 1'b1;
                push_idx = IDX_W'(i);
                push_lvl = stable_q[i];
                push_ts  = tscap_q[i];
                grant[i] = 1'b1;
            end
        end
    end

    // A commit in the same cycle as its own push re-arms the pending bit.
    assign pending_d = (pending_q & ~grant) | commit;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stable_q  <= '0;
            pending_q <= '0;
            ts_q      <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                dbc_q[i]   <= '0;
                tscap_q[i] <= '0;
            end
        end else begin
            stable_q  <= stable_d;
            pending_q <= pending_d;
            ts_q      <= ts_q + TS_WIDTH'(1);
            for (int i = 0; i < NUM_IN; i++) begin
                dbc_q[i]   <= dbc_d[i];
                tscap_q[i] <= tscap_d[i];
            end
        end
    end

    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid & evt_ready;
    assign full      = (count_q == FIFO_FULL);
    // A pop frees a slot in the same cycle, so a full queue still accepts.
    assign do_write  = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (do_write && !pop) begin
            count_d = count_q + CNT_FW'(1);
        end else if (pop && !do_write) begin
            count_d = count_q - CNT_FW'(1);
        end
        // A drop in the clearing cycle keeps the flag set.
        overflow_d = (overflow_q & ~clear_overflow) | drop;
        irq_d      = (count_d >= IRQ_LEVEL) | overflow_d;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            if (do_write) begin
                mem_q[wr_ptr_q] <= {push_idx, push_lvl, push_ts};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

    assign {evt_index, evt_level, evt_timestamp} = mem_q[rd_ptr_q];
    assign stable_state = stable_q;
    assign fifo_count   = count_q;
    assign overflow     = overflow_q;
    assign irq          = irq_q;

endmodule
